// File: rtl/bin2bcd_pkg.sv
// ============================================================================
// bin2bcd_pkg : shared types and helpers for the sequential binary-to-BCD block
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin2bcd_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Largest value representable in the given number of decimal digits.
  function automatic longint max_val(input int digits);
    longint v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_adj3.sv
// ============================================================================
// bcd_adj3 : one double-dabble digit correction, adds 3 when the nibble is >= 5
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [NIB_W-1:0] din,
  output logic [NIB_W-1:0] dout
);

  // A valid BCD digit is at most 9, so the sum is at most 12 and fits 4 bits.
  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : iterative shift-and-add-3 binary to packed-BCD converter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [IN_W-1:0]           bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [NIB_W*DIGITS-1:0]   bcd_out,
  output logic                      ovf
);

  localparam int     c_bcd_w   = NIB_W * DIGITS;
  localparam int     c_cnt_w   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam longint c_max_val = max_val(DIGITS);
  localparam bit     c_clamp   = c_max_val < (longint'(1) << IN_W);
  // When every IN_W-bit value is displayable the clamp threshold is all-ones,
  // so the compare below can never fire.
  localparam logic [IN_W-1:0]    c_max_in = c_clamp ? IN_W'(c_max_val) : '1;
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(IN_W - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IN_W-1:0]       r_bin;
  logic [c_bcd_w-1:0]    r_bcd;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_ovf_pend;

  logic                  w_load;
  logic                  w_finish;
  logic                  w_over;
  logic [c_bcd_w-1:0]    w_adj;
  logic [c_bcd_w-1:0]    w_bcd_sh;
  logic [IN_W-1:0]       w_bin_sh;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (r_bcd[g*NIB_W +: NIB_W]),
      .dout (w_adj[g*NIB_W +: NIB_W])
    );
  end

  assign w_over   = (bin_in > c_max_in);
  assign w_bcd_sh = {w_adj[c_bcd_w-2:0], r_bin[IN_W-1]};
  assign w_bin_sh = {r_bin[IN_W-2:0], 1'b0};
  assign busy     = (r_state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          w_load      = 1'b1;
        end
      end
      SHIFT: begin
        if (r_cnt == c_last) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      ovf        <= 1'b0;
    end else begin
      done <= w_finish;
      if (w_load) begin
        r_bin      <= w_over ? c_max_in : bin_in;
        r_ovf_pend <= w_over;
        r_bcd      <= '0;
        r_cnt      <= '0;
      end else if (r_state == SHIFT) begin
        r_bcd <= w_bcd_sh;
        r_bin <= w_bin_sh;
        r_cnt <= r_cnt + 1'b1;
      end
      // Outputs only ever take the final shifted value, never a partial one.
      if (w_finish) begin
        bcd_out <= w_bcd_sh;
        ovf     <= r_ovf_pend;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// tb_bin2bcd_seq : self-checking bench, arithmetic reference model plus
//                  directed vectors with literal expectations
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = 14;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a countdown per accepted request, results from arithmetic.
  int          m_cnt;
  int          m_val;
  logic        m_povf;
  logic        m_done;
  logic        m_ovf;
  logic [15:0] m_bcd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_val  <= 0;
      m_povf <= 1'b0;
      m_done <= 1'b0;
      m_ovf  <= 1'b0;
      m_bcd  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt  <= LAT;
          m_val  <= int'(bin_in);
          m_povf <= (int'(bin_in) > 9999);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_bcd  <= to_bcd(m_val);
          m_ovf  <= m_povf;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    for (int d = 0; d < DIGITS; d++) begin
      chk("nibble<=9", 32'(bcd_out[d*4 +: 4] <= 4'd9), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge; returns cycles until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) chk("done_timeout", 32'(lat), 32'(LAT));
  endtask

  task automatic convert(input int val, input logic [15:0] exp_bcd, input logic exp_ovf,
                         input bit lit);
    int lat;
    bin_in = 14'(val);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = 14'($urandom_range(0, 16383));
    wait_done(lat);
    if (lit) begin
      chk("latency", 32'(lat), 32'(LAT));
      chk("lit_bcd", 32'(bcd_out), 32'(exp_bcd));
      chk("lit_ovf", 32'(ovf), 32'(exp_ovf));
    end
  endtask

  initial begin
    int lat;
    int busy_cycles;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Zero, also measuring the busy window length.
    bin_in = 14'd0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
    chk("busy_width", 32'(busy_cycles), 32'(LAT));
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_bcd", 32'(bcd_out), 32'h0000);
    chk("zero_ovf", 32'(ovf), 32'd0);

    convert(1234,  16'h1234, 1'b0, 1'b1);
    convert(9999,  16'h9999, 1'b0, 1'b1);
    convert(12000, 16'h9999, 1'b1, 1'b1);
    convert(16383, 16'h9999, 1'b1, 1'b1);
    convert(10000, 16'h9999, 1'b1, 1'b1);
    convert(9998,  16'h9998, 1'b0, 1'b1);
    convert(305,   16'h0305, 1'b0, 1'b1);

    // A start during busy must be ignored.
    bin_in = 14'd42;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin_in = 14'd77;
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("ign_latency", 32'(lat + 5), 32'(LAT));
    chk("ign_bcd", 32'(bcd_out), 32'h0042);
    // Start held in the done cycle is accepted at once.
    convert(77, 16'h0077, 1'b0, 1'b1);

    // Asynchronous reset mid-conversion.
    bin_in = 14'd5678;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bcd", 32'(bcd_out), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    convert(305, 16'h0305, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      convert(int'($urandom_range(0, 16383)), 16'h0, 1'b0, 1'b0);
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Iterative binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the per-digit BCD-to-seven-segment decoders.
- Accepts a binary value on a start/busy/done handshake and produces DIGITS packed BCD nibbles. Each nibble feeds one decoder's 4-bit bcd input.
- Clamps out-of-range inputs to the largest displayable value and flags the clamp.

Parameters:
- IN_W, 14, width of binary input.
- DIGITS, 4, number of BCD output digits; MAX_VAL = 10^DIGITS - 1 (9999 at default).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bin_in; sampled only while busy=0.
- bin_in  input  IN_W  unsigned binary value; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/ovf update.
- bcd_out  output  4*DIGITS  packed BCD; [3:0] = ones, [7:4] = tens, and so on.
- ovf  output  1  high if the last completed conversion was clamped.

Behaviour:
- Reset, asynchronous on rst_n=0: state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, internal shift/BCD registers and counter cleared. Release is synchronous to clk.
- FSM states: IDLE, SHIFT.
- IDLE -> SHIFT on an edge where start=1. That edge:
  - loads bin_reg = min(bin_in, MAX_VAL);
  - latches ovf_pend = (bin_in > MAX_VAL);
  - clears bcd_reg to 0 and cnt to 0;
  - sets busy=1.
- SHIFT, each edge:
  - every nibble of bcd_reg that is >= 5 gets +3 (no carry between nibbles);
  - then the concatenation {bcd_reg, bin_reg} shifts left by 1, so the bin_reg MSB enters the bcd_reg LSB;
  - cnt increments.
- After the IN_W-th shift edge (cnt reaches IN_W-1 before that edge), on the same edge:
  - state -> IDLE, busy -> 0;
  - bcd_out <= shifted result, ovf <= ovf_pend, done <= 1.
- Latency: done and the new bcd_out are visible exactly IN_W cycles after the accepting edge (14 at default). busy is high for exactly IN_W cycles.
- done is high for one cycle only, then returns to 0.
- bcd_out and ovf hold their last value until the next completion. They never show intermediate values.
- start while busy=1 is ignored; no queueing.
- start asserted in the done cycle (busy=0) is accepted, giving back-to-back conversions with no dead cycle.
- bin_in changes after the accepting edge have no effect.
- Reset mid-conversion aborts the conversion. Outputs return to reset values and the partial result is discarded.
- Width rules:
  - nibble add-3 is 4-bit; inputs to it are always <= 9, so it never overflows;
  - cnt width = clog2(IN_W);
  - the clamp compare is IN_W-bit unsigned.
- Every bcd_out nibble is 0-9 at all times.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum {IDLE, SHIFT};
  - function computing MAX_VAL from DIGITS;
  - BCD nibble width constant (4).
- One sub-module, bcd_adj3: combinational 4-bit "if >= 5 then +3". Instantiated DIGITS times via generate in the SHIFT datapath.

Test Plan:
- Reset, then bin_in=0, start pulse -> busy high 14 cycles; done pulse on cycle 14; bcd_out=16'h0000; ovf=0.
- bin_in=1234, start -> bcd_out=16'h1234, ovf=0, done exactly 14 cycles after accept.
- bin_in=9999 -> bcd_out=16'h9999, ovf=0. bin_in=12000 -> bcd_out=16'h9999, ovf=1. bin_in=16383 -> bcd_out=16'h9999, ovf=1.
- Convert 42; assert start with bin_in=77 on cycle 5 of busy -> ignored; single done; bcd_out=16'h0042. Then start held during the done cycle with bin_in=77 -> accepted immediately; second done 14 cycles later with bcd_out=16'h0077.
- Convert 5678, assert rst_n=0 at cycle 7 of busy -> busy, done, bcd_out, ovf go 0 immediately (asynchronously). After release, bin_in=305 -> bcd_out=16'h0305.
- Random sweep of 0..16383 against a reference model: each nibble <= 9, value = min(in, 9999), ovf = (in > 9999), done width = 1 cycle.
